// File: rtl/cpci_arb_pkg.sv
// Shared constants for the CPCI transfer-FIFO write arbiter.
// State encoding and default burst limit used by the arbiter and its users.
package cpci_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;

  localparam int ARB_MAX_BURST = 8;

endpackage

// File: rtl/cpci_fifo_wr_arb.sv
// Round-robin, burst-locked two-requester arbiter for the CPCI FIFO write port; grant one cycle after req.
// Accept/write are combinational and gated by fifo_full; a stalled word simply waits under the held grant.
module cpci_fifo_wr_arb
  import cpci_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = ARB_MAX_BURST,
  parameter int BURST_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic                  last0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic                  gnt0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic                  last1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  err_wr_no_gnt,
  input  logic                  err_clr
);

  localparam logic [BURST_BITS-1:0] CNT_LAST = BURST_BITS'(MAX_BURST - 1);

  logic [1:0]            state_q, state_d;
  logic [BURST_BITS-1:0] cnt_q, cnt_d;
  logic                  last_served_q, last_served_d;
  logic                  err_q, err_d;

  logic acc_cur, last_cur, req_cur, req_oth, fin, release_c;
  logic [1:0] oth_state;

  assign gnt0 = (state_q == ARB_GNT0);
  assign gnt1 = (state_q == ARB_GNT1);

  assign ack0       = gnt0 & wr0 & ~fifo_full;
  assign ack1       = gnt1 & wr1 & ~fifo_full;
  assign fifo_wr_en = ack0 | ack1;
  assign fifo_din   = gnt1 ? din1 : din0;

  assign err_wr_no_gnt = err_q;

  always_comb begin
    // View the current owner's signals uniformly so both grant states share one release rule.
    acc_cur   = gnt1 ? ack1  : ack0;
    last_cur  = gnt1 ? last1 : last0;
    req_cur   = gnt1 ? req1  : req0;
    req_oth   = gnt1 ? req0  : req1;
    oth_state = gnt1 ? ARB_GNT0 : ARB_GNT1;
    fin       = acc_cur & last_cur;
    release_c = fin | (acc_cur & (cnt_q == CNT_LAST)) | ~req_cur;

    state_d       = state_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;

    case (state_q)
      ARB_IDLE: begin
        if (req0 && (!req1 || last_served_q)) state_d = ARB_GNT0;
        else if (req1)                        state_d = ARB_GNT1;
      end
      ARB_GNT0, ARB_GNT1: begin
        if (release_c) begin
          last_served_d = gnt1;
          cnt_d         = '0;
          if (req_oth)              state_d = oth_state;
          else if (req_cur && !fin) state_d = state_q;
          else                      state_d = ARB_IDLE;
        end else if (acc_cur) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    err_d = err_clr ? 1'b0 : (err_q | (wr0 & ~gnt0) | (wr1 & ~gnt1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_cpci_fifo_wr_arb.sv
// Randomized bench for cpci_fifo_wr_arb: transaction-level arbitration model plus write scoreboard.
module tb_cpci_fifo_wr_arb;

  localparam int DW = 32;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0, wr0, last0, req1, wr1, last1;
  logic [DW-1:0] din0, din1, fifo_din;
  logic gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_full, err_wr_no_gnt, err_clr;

  cpci_fifo_wr_arb #(.DATA_WIDTH(DW), .MAX_BURST(MB), .BURST_BITS(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .wr0(wr0), .last0(last0), .din0(din0), .gnt0(gnt0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .last1(last1), .din1(din1), .gnt1(gnt1), .ack1(ack1),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .err_wr_no_gnt(err_wr_no_gnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester word queues: bit 32 marks the final word of a burst.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [DW-1:0] exp_q[$];
  int seq = 0;

  task automatic gen(input int k, input int len);
    for (int i = 0; i < len; i++) begin
      logic [32:0] w;
      w = {(i == len - 1), (k == 1) ? 8'hB1 : 8'hA0, 24'(seq)};
      seq++;
      if (k == 0) q0.push_back(w); else q1.push_back(w);
    end
  endtask

  // Reference model: who owns the port and how many words the current burst has taken.
  int owner = -1;
  int words = 0;
  int ls = 1;
  bit m_err = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    logic [1:0] rq, wv, lv;
    int k;
    bit acc, fin, done;
    if (!reset_n) begin
      owner = -1; words = 0; ls = 1; m_err = 1'b0;
    end else begin
      rq = {req1, req0}; wv = {wr1, wr0}; lv = {last1, last0};
      if (err_clr) m_err = 1'b0;
      else if ((wv[0] && owner != 0) || (wv[1] && owner != 1)) m_err = 1'b1;
      if (owner < 0) begin
        if (rq == 2'b11) owner = (ls == 1) ? 0 : 1;
        else if (rq[0]) owner = 0;
        else if (rq[1]) owner = 1;
      end else begin
        k = owner;
        acc = wv[k] && !fifo_full;
        if (acc) words++;
        fin = acc && lv[k];
        done = fin || (words == MB) || !rq[k];
        if (done) begin
          ls = k;
          words = 0;
          if (rq[1-k]) owner = 1 - k;
          else if (rq[k] && !fin) owner = k;
          else owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e0, e1;
    e0 = (owner == 0) && wr0 && !fifo_full;
    e1 = (owner == 1) && wr1 && !fifo_full;
    chk("gnt0", gnt0, owner == 0);
    chk("gnt1", gnt1, owner == 1);
    chk("ack0", ack0, e0);
    chk("ack1", ack1, e1);
    chk("fifo_wr_en", fifo_wr_en, e0 | e1);
    chk("err_wr_no_gnt", err_wr_no_gnt, m_err);
    if (e0) exp_q.push_back(din0);
    else if (e1) exp_q.push_back(din1);
  end

  always @(negedge clk) begin
    #1;
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got data %0h, no write expected at %0t", fifo_din, $time);
      end else begin
        chk("fifo_din", fifo_din, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic g, input int sz, input logic [32:0] head, input logic cur_req,
                       output logic r, output logic w, output logic l, output logic [DW-1:0] d);
    if (sz == 0) r = 1'b0;
    else if (!cur_req) r = ($urandom_range(0, 3) == 0);
    else r = ($urandom_range(0, 31) != 0);
    w = r && g && (sz > 0) && ($urandom_range(0, 7) != 0);
    if (!g && $urandom_range(0, 63) == 0) w = 1'b1;
    l = w && head[32];
    d = (sz > 0) ? head[31:0] : $urandom;
  endtask

  initial begin
    logic a0, a1, wen;
    logic [32:0] h0, h1;
    int fcount, rdp;
    req0 = 0; wr0 = 0; last0 = 0; din0 = '0;
    req1 = 0; wr1 = 0; last1 = 0; din1 = '0;
    fifo_full = 0; err_clr = 0; fcount = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_err", err_wr_no_gnt, 1'b0);
    reset_n = 1;
    gen(0, 2); gen(1, 2);
    @(posedge clk); #1;
    req0 = 1; req1 = 1;

    for (int cyc = 0; cyc < 4500; cyc++) begin
      @(negedge clk);
      a0 = ack0; a1 = ack1; wen = fifo_wr_en;
      @(posedge clk); #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      rdp = (cyc >= 4000) ? 0 : (((cyc / 400) % 2) == 1 ? 4 : 0);
      if (wen && fcount < 8) fcount++;
      if (fcount > 0 && $urandom_range(0, rdp) == 0) fcount--;
      fifo_full = (fcount == 8);
      if (cyc < 4000) begin
        if (q0.size() == 0 && $urandom_range(0, 7) == 0) gen(0, $urandom_range(1, 12));
        if (q1.size() == 0 && $urandom_range(0, 7) == 0) gen(1, $urandom_range(1, 12));
      end
      h0 = (q0.size() > 0) ? q0[0] : 33'd0;
      h1 = (q1.size() > 0) ? q1[0] : 33'd0;
      if (cyc > 0) begin
        drive(gnt0, q0.size(), h0, req0, req0, wr0, last0, din0);
        drive(gnt1, q1.size(), h1, req1, req1, wr1, last1, din1);
      end
      err_clr = ($urandom_range(0, 7) == 0);
      if (cyc == 1500 || cyc == 2900) begin
        wr0 = 0; wr1 = 0; last0 = 0; last1 = 0;
        #2 reset_n = 0;
        #1;
        chk("midrst_gnt0", gnt0, 1'b0);
        chk("midrst_gnt1", gnt1, 1'b0);
        chk("midrst_wr_en", fifo_wr_en, 1'b0);
        chk("midrst_err", err_wr_no_gnt, 1'b0);
        @(posedge clk); #1;
        reset_n = 1;
      end
    end
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpci_fifo_wr_arb.md
Name: cpci_fifo_wr_arb

Overview:
Two-requester write arbiter for the CPCI 8x32 transfer FIFO. It shares the FIFO write port between two sources, for example the PCI target write path and the DMA engine. Arbitration is round-robin with burst locking and a maximum burst length. It muxes data and write enable onto the FIFO, gates writes against FIFO full, and returns a per-word accept to the granted requester.

Parameters:
DATA_WIDTH, 32, width of the data path and FIFO word.
MAX_BURST, 8, maximum words accepted per grant before forced re-arbitration.
BURST_BITS, 3, width of the burst counter; must equal log2(MAX_BURST).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous active-low reset.
req0  input  1  requester 0 wants the FIFO.
wr0  input  1  requester 0 word valid; only honoured while gnt0=1.
last0  input  1  requester 0 final word of the burst; qualified by ack0.
din0  input  DATA_WIDTH  requester 0 data.
gnt0  output  1  registered grant to requester 0.
ack0  output  1  combinational: requester 0 word written this cycle.
req1, wr1, last1, din1, gnt1, ack1: same as the requester 0 ports, for requester 1.
fifo_din  output  DATA_WIDTH  data to the FIFO.
fifo_wr_en  output  1  FIFO write enable.
fifo_full  input  1  FIFO full flag.
err_wr_no_gnt  output  1  sticky flag: a wr was asserted without the matching grant.
err_clr  input  1  synchronous clear of err_wr_no_gnt.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, gnt0=gnt1=0.
  - burst_cnt=0, err_wr_no_gnt=0.
  - last_served=1, so requester 0 wins the first contention.
  - Reset mid-burst drops the grant immediately. A word presented in that cycle is not written, because fifo_wr_en depends on gnt.
- States: IDLE, GNT0, GNT1. gnt0=(state==GNT0), gnt1=(state==GNT1). The two grants are never both high.
- accept_x = gnt_x & wr_x & ~fifo_full. This gives ack_x = accept_x and fifo_wr_en = accept0 | accept1.
- fifo_din = din1 when gnt1, else din0. The FIFO ignores fifo_din when fifo_wr_en=0.
- IDLE:
  - Only one req high: go to that requester's GNT state.
  - Both high: grant the requester that is not last_served.
  - Neither high: stay in IDLE.
  - Grant latency is one cycle: req sampled in cycle N gives gnt in cycle N+1.
- GNTx, release condition is any of:
  - accept_x & last_x;
  - accept_x & burst_cnt==MAX_BURST-1;
  - req_x==0.
- GNTx, on release:
  - last_served<=x and burst_cnt<=0.
  - Next state, in priority order: GNT of the other requester if its req=1; else GNTx again (fresh burst) if req_x=1 and the release was not caused by last_x; else IDLE.
  - Handoff has zero idle cycles: the other requester may be acked in the cycle after release.
- GNTx, no release: burst_cnt increments on each accept_x and holds otherwise.
- fifo_full=1: no accept, burst_cnt holds, and the grant persists as long as req_x stays high. The requester holds wr and din until it sees ack.
- Simultaneous last_x and burst-limit: treated as a single release. last takes precedence, so there is no re-grant to the same requester.
- burst_cnt wraps only through the reset-on-release rule; it never exceeds MAX_BURST-1.
- err_wr_no_gnt:
  - Set when (wr0 & ~gnt0) | (wr1 & ~gnt1).
  - err_clr has priority over set within the same cycle.
- Throughput: one word per clk while granted and the FIFO is not full.

Decomposition:
- Shared package cpci_arb_pkg holds:
  - state encoding constants ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2;
  - the MAX_BURST default.
- No sub-module. The state machine, burst counter and data mux stay in the single module. The FIFO is instantiated alongside it by the parent, not inside it.

Test Plan:
- req0=1 alone, wr0 for 3 words (0xA0,0xA1,0xA2), last0 on 0xA2 -> gnt0 one cycle after req0; ack0 on 3 consecutive cycles; the FIFO holds A0..A2; IDLE on the next cycle.
- req0 and req1 high together after reset, each sending a 2-word burst with last -> requester 0 is served first, then gnt1 on the cycle after release with no idle cycle; FIFO order is r0w0, r0w1, r1w0, r1w1.
- req0 held high with 10 words and no last, req1 high -> after the 8th ack0, gnt1 is asserted; requester 1's burst completes; requester 0 is re-granted and its remaining 2 words are written.
- Full FIFO (8 words prefilled, fifo_full=1) while granted and wr0=1 -> ack0=0 and fifo_wr_en=0; burst_cnt is unchanged; after one external read, ack0 fires on the next cycle.
- reset_n pulsed low mid-burst after 2 accepts -> gnt0 falls asynchronously; no fifo_wr_en during reset; after release, req0 is re-granted from burst_cnt=0.
- wr1=1 while gnt0 -> err_wr_no_gnt=1 next cycle and stays sticky; err_clr=1 for one cycle clears it, and no FIFO write occurs for wr1.
